// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and sizing for the iterative multiply/divide unit
package muldiv_pkg;
  localparam int data_width = 32;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on the accumulator
module muldiv_step #(
  parameter int data_width = muldiv_pkg::data_width
) (
  input  logic [2*data_width:0]  i_acc,
  input  logic [data_width-1:0]  i_operand,
  input  logic                   i_div,
  output logic [2*data_width:0]  o_acc
);
  localparam int W = data_width;
  logic [W:0]   w_sum;
  logic [W:0]   w_rem;
  logic [W+1:0] w_diff;
  // multiply keeps the carry in bit W of the sum; divide holds a W+1 bit partial remainder
  always_comb begin
    w_sum  = i_acc[2*W:W] + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_rem  = i_acc[2*W-1:W-1];
    w_diff = {1'b0, w_rem} - {2'b00, i_operand};
    o_acc  = !i_div ? {1'b0, w_sum, i_acc[W-1:1]} :
             !w_diff[W+1] ? {w_diff[W:0], i_acc[W-2:0], 1'b1} : {w_rem, i_acc[W-2:0], 1'b0};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-iteration MIPS-style MULT/MULTU/DIV/DIVU unit producing hi/lo
module muldiv_unit #(
  parameter int data_width  = muldiv_pkg::data_width,
  parameter int count_width = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [data_width-1:0] operand_a,
  input  logic [data_width-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo,
  output logic                  div_by_zero
);
  import muldiv_pkg::*;
  localparam int W = data_width;
  state_t               r_state, w_next;
  logic [2*W:0]         r_acc, w_acc_next;
  logic [W-1:0]         r_opnd, r_a, r_hi, r_lo, w_hi, w_lo, w_mag_a, w_mag_b, w_q, w_r;
  logic [2*W-1:0]       w_prod;
  logic [count_width-1:0] r_count;
  logic                 r_div, r_neg_q, r_neg_r, r_bz, r_dbz, w_signed, w_div, w_sa, w_sb;
  muldiv_step #(.data_width(W)) u_step (
    .i_acc(r_acc), .i_operand(r_opnd), .i_div(r_div), .o_acc(w_acc_next)
  );
  // r_neg_q doubles as the product sign for multiplies
  always_comb begin
    w_signed = op == OP_MULT || op == OP_DIV;
    w_div    = op == OP_DIVU || op == OP_DIV;
    w_sa     = w_signed & operand_a[W-1];
    w_sb     = w_signed & operand_b[W-1];
    w_mag_a  = w_sa ? -operand_a : operand_a;
    w_mag_b  = w_sb ? -operand_b : operand_b;
    w_prod   = r_neg_q ? -r_acc[2*W-1:0] : r_acc[2*W-1:0];
    w_q      = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    w_r      = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    w_hi     = !r_div ? w_prod[2*W-1:W] : r_bz ? r_a : w_r;
    w_lo     = !r_div ? w_prod[W-1:0] : r_bz ? '1 : w_q;
  end
  always_comb begin
    w_next = r_state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
             r_state == ST_RUN  ? (&r_count ? ST_FIX : ST_RUN) :
             r_state == ST_FIX  ? ST_DONE : ST_IDLE;
    busy   = r_state != ST_IDLE;
    done   = r_state == ST_DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_div   <= w_div;
      r_a     <= operand_a;
      r_opnd  <= w_div ? w_mag_b : w_mag_a;
      r_acc   <= (2*W+1)'(w_div ? w_mag_a : w_mag_b);
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      r_bz    <= operand_b == '0;
      r_count <= '0;
      r_dbz   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + 1'b1;
    end else if (r_state == ST_FIX) begin
      r_hi    <= w_hi;
      r_lo    <= w_lo;
      r_dbz   <= r_div & r_bz;
    end
  end
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven scoreboard bench for muldiv_unit plus busy/reset corner sequences
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;
  logic        clk = 0, rst = 1, start = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;
  int          n_tests = 0, n_fail = 0;
  vec_t        sb[$];
  vec_t        m_e;
  vec_t        vecs[14];
  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand_a(a), .operand_b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && done) begin
      if (sb.size() == 0) chk("unexpected_done", done, 0);
      else begin
        m_e = sb.pop_front();
        chk("hi", hi, m_e.hi);
        chk("lo", lo, m_e.lo);
        chk("div_by_zero", dbz, m_e.dbz);
      end
    end
  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic launch(input vec_t v, input bit push);
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1;
    if (push) sb.push_back(v);
    @(negedge clk);
    start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask
  task automatic run_vec(input vec_t v);
    int k;
    launch(v, 1);
    chk("busy_in_run", busy, 1);
    wait_done(k);
    chk("latency", k, 34);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask
  initial begin
    int k;
    logic [31:0] keep_hi, keep_lo;
    vecs = '{
      '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0},
      '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0},
      '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0},
      '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0},
      '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
      '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
      '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1},
      '{OP_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0},
      '{OP_DIVU,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1},
      '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1},
      '{OP_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0},
      '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0},
      '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0},
      '{OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0}
    };
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", dbz, 0);
    rst = 0;
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);
    // starts during RUN and DONE must be ignored
    launch('{OP_MULTU, 32'h1234, 32'h10, 32'h0, 32'h12340, 1'b0}, 1);
    repeat (5) @(negedge clk);
    start = 1; op = OP_DIV; a = 32'hDEAD; b = 32'h3;
    @(negedge clk);
    start = 0;
    wait_done(k);
    chk("ignore_done_seen", done, 1);
    start = 1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 0;
    chk("ignore_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("ignore_busy_later", busy, 0);
    chk("ignore_hi", hi, 32'h0);
    chk("ignore_lo", lo, 32'h12340);
    // async reset mid-divide
    launch('{OP_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0}, 0);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_dbz", dbz, 0);
    @(negedge clk);
    rst = 0;
    chk("post_rst_busy", busy, 0);
    run_vec('{OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0});
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-cycle multiply/divide unit directly downstream of the register file.
- Consumes read_data_1/read_data_2 as operand_a/operand_b and produces a 64-bit result in hi/lo.
- Control asserts start, stalls on busy, then writes hi or lo back through write_data.
- Supports MIPS-style MULT/MULTU/DIV/DIVU.

Parameters:
- data_width, 32, operand and hi/lo width.
- count_width, 5, iteration counter width; must equal clog2(data_width).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- operand_a  input  data_width  multiplicand or dividend (register file read_data_1).
- operand_b  input  data_width  multiplier or divisor (register file read_data_2).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle on.
- hi  output  data_width  product upper half, or remainder.
- lo  output  data_width  product lower half, or quotient.
- div_by_zero  output  1  set with done when a divide had operand_b==0; held until the next accepted start.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; internal accumulators and counter cleared. No partial result is ever written to hi/lo.
- States: IDLE, RUN, FIX, DONE.
- IDLE -> RUN on a clk edge with start=1.
  - Latch op.
  - Latch the magnitudes of the operands. For the signed ops, take the two's-complement absolute value and record each sign.
  - Clear count and the accumulator; clear div_by_zero.
- RUN: one iteration per edge for 32 edges. count increments; at count==31 go to FIX.
  - Multiply: shift-add. If multiplier LSB is 1, add the multiplicand to the upper accumulator; then shift the 64-bit accumulator right by 1, keeping the carry.
  - Divide: restoring. Shift remainder:quotient left by 1; trial-subtract the divisor from the remainder; if the result is non-negative, keep it and set quotient LSB=1.
- FIX: one edge. Apply the sign correction, register hi/lo, go to DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - DIVU/DIV with operand_b==0: lo=all ones, hi=operand_a as latched (original, not magnitude), div_by_zero=1.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- DONE: done=1 for exactly one cycle; next edge -> IDLE.
- Latency: start sampled at edge E0; hi/lo/done valid after E33; busy falls after E34. A new start is accepted no earlier than E34.
- start while busy (RUN/FIX/DONE) is ignored; operand/op changes after E0 have no effect.
- hi/lo hold their value until overwritten at a later FIX or cleared by rst.
- Width rules: the accumulator is 2*data_width+1 bits internally so the carry is kept. All negation is two's complement modulo the field width.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
  - state encodings ST_IDLE/ST_RUN/ST_FIX/ST_DONE;
  - constant data_width=32.
- One sub-module, muldiv_step: purely combinational single-iteration datapath (inputs: accumulator, operand, op class; output: next accumulator). The top module owns the FSM, counter, latches and sign fix-up.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at E0 -> hi=0xFFFFFFFE, lo=0x00000001, done high only in the cycle after E33, busy low after E34.
- MULT -3 (0xFFFFFFFD) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1; a following MULTU 2*3 start clears div_by_zero -> lo=6.
- start pulsed with different operands during RUN and DONE -> ignored; the first result is unchanged.
- rst asserted at E10 of a DIVU -> busy=0, hi=lo=0 immediately (async); a fresh MULTU 6*7 then yields lo=42 with full 33-edge latency.
